// File: rtl/hilo_div_unit_pkg.sv
// Shared encodings for the HI/LO divide unit: op codes, FSM states and the
// divide-by-zero LO value.
package hilo_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        HL_DIV  = 2'd0,
        HL_DIVU = 2'd1,
        HL_MTHI = 2'd2,
        HL_MTLO = 2'd3
    } hl_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } hl_state_e;

    localparam logic [W-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_div_unit_if.sv
// EX-side op bus plus the divider operand/result path of the HI/LO unit.
interface hilo_div_if;
    import hilo_pkg::*;

    logic         op_valid;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_sign;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output op_valid, op, rs_val, rt_val, flush, div_q, div_r,
        input  div_dividend, div_divisor, div_sign, busy, hi, lo
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush, div_q, div_r,
        output div_dividend, div_divisor, div_sign, busy, hi, lo
    );

endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register owner: holds divider operands for DIV_LAT cycles, then
// commits quotient/remainder; also executes MTHI/MTLO.
module hilo_div_unit
    import hilo_pkg::*;
#(
    parameter int DIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    hilo_div_if.slave  bus
);

    localparam int CW = 4;

    hl_state_e    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [W-1:0] hi_q, lo_q, dvd_q, dvs_q;
    logic         sign_q;
    logic         accept, is_div, done;

    assign is_div = (bus.op == HL_DIV) || (bus.op == HL_DIVU);
    assign accept = bus.op_valid && !bus.flush && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_div) begin
                    state_nxt = ST_RUN;
                    count_nxt = CW'(DIV_LAT - 1);
                end
            end
            ST_RUN: begin
                // flush beats completion: an aborted divide never writes HI/LO
                if (bus.flush) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else if (count == '0) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            if (accept && is_div) begin
                dvd_q  <= bus.rs_val;
                dvs_q  <= bus.rt_val;
                sign_q <= (bus.op == HL_DIV);
            end
            if (accept && bus.op == HL_MTHI) hi_q <= bus.rs_val;
            if (accept && bus.op == HL_MTLO) lo_q <= bus.rs_val;
            if (done) begin
                // divide by zero ignores the divider and returns a fixed pattern
                if (dvs_q == '0) begin
                    lo_q <= DIV0_LO;
                    hi_q <= dvd_q;
                end else begin
                    lo_q <= bus.div_q;
                    hi_q <= bus.div_r;
                end
            end
        end
    end

    assign bus.busy         = (state == ST_RUN);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;
    assign bus.div_sign     = sign_q;

    // The hazard unit must stall HI/LO ops while busy; one arriving here is dropped.
    always @(posedge clk) begin
        if (rst_n) begin
            op_while_busy: assert (!(state == ST_RUN && bus.op_valid && !bus.flush))
                else $warning("hilo_div_unit: op_valid while busy, op dropped");
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Randomized and directed checks of hilo_div_unit against an arithmetic model.
module tb_hilo_div_unit;
    import hilo_pkg::*;

    localparam int DIV_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    hilo_div_if bus();

    hilo_div_unit #(.DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Divider stand-in: real quotient/remainder, junk when divisor is zero.
    function automatic logic [63:0] divider(input logic [31:0] a, b, input logic s);
        longint sa, sb;
        if (b == 0) return {a ^ 32'h1234_0000, ~a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    assign {bus.div_q, bus.div_r} = divider(bus.div_dividend, bus.div_divisor, bus.div_sign);

    // Architectural result of a divide: {lo, hi}.
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, b);
        longint sa, sb;
        if (b == 0) return {32'hFFFF_FFFF, a};
        if (op == HL_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    task automatic chk_hilo(input string name);
        vectors++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h expected hi=%h lo=%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic chk_busy(input string name, input logic want);
        vectors++;
        if (bus.busy !== want) begin
            errors++;
            $display("FAIL %s: busy=%b expected %b", name, bus.busy, want);
        end
    endtask

    task automatic chk_ops(input string name, input logic [31:0] a, b, input logic s);
        vectors++;
        if (bus.div_dividend !== a || bus.div_divisor !== b || bus.div_sign !== s) begin
            errors++;
            $display("FAIL %s: dvd=%h dvs=%h sign=%b expected %h %h %b", name,
                     bus.div_dividend, bus.div_divisor, bus.div_sign, a, b, s);
        end
    endtask

    // Issue a divide at the current negedge; flush_at selects a RUN cycle to flush (-1 none).
    // Returns at the negedge of the first busy=0 cycle.
    task automatic do_div(input logic [1:0] op, input logic [31:0] a, b, input int flush_at);
        logic [63:0] res;
        bus.op_valid = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
        for (int i = 0; i < DIV_LAT; i++) begin
            chk_busy("div_busy", 1'b1);
            chk_ops("div_hold", a, b, op == HL_DIV);
            if (i == flush_at) begin
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
                chk_busy("flush_busy", 1'b0);
                chk_hilo("flush_hilo");
                chk_ops("flush_keep", a, b, op == HL_DIV);
                return;
            end
            @(negedge clk);
        end
        res = ref_div(op, a, b);
        exp_lo = res[63:32];
        exp_hi = res[31:0];
        chk_busy("div_done_busy", 1'b0);
        chk_hilo("div_result");
    endtask

    task automatic do_mt(input logic [1:0] op, input logic [31:0] a);
        bus.op_valid = 1'b1; bus.op = op; bus.rs_val = a;
        @(negedge clk);
        bus.op_valid = 1'b0;
        if (op == HL_MTHI) exp_hi = a; else exp_lo = a;
        chk_busy("mt_busy", 1'b0);
        chk_hilo("mt_hilo");
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_busy("reset_busy", 1'b0);
        chk_hilo("reset_hilo");
        chk_ops("reset_ops", 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        do_div(HL_DIVU, 32'd100, 32'd7, -1);
        vectors++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL divu_100_7: lo=%0d hi=%0d expected 14 2", bus.lo, bus.hi);
        end
    endtask

    task automatic test_signed();
        do_div(HL_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        vectors++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_m7_2: lo=%h hi=%h expected fffffffd ffffffff", bus.lo, bus.hi);
        end
        do_div(HL_DIVU, 32'hFFFF_FFF9, 32'd2, -1);
        vectors++;
        if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL divu_m7_2: lo=%h hi=%h expected 7ffffffc 00000001", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_zero_ovf();
        do_div(HL_DIV, 32'h1234_5678, 32'd0, -1);
        vectors++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL div_by_zero: lo=%h hi=%h expected ffffffff 12345678", bus.lo, bus.hi);
        end
        do_div(HL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        vectors++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL div_overflow: lo=%h hi=%h expected 80000000 00000000", bus.lo, bus.hi);
        end
    endtask

    task automatic test_mthi_mtlo();
        do_mt(HL_MTHI, 32'hA5A5_A5A5);
        do_mt(HL_MTLO, 32'h5A5A_5A5A);
        vectors++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL mt_pair: hi=%h lo=%h expected a5a5a5a5 5a5a5a5a", bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush();
        do_div(HL_DIV, 32'd1000, 32'd3, 1);
        do_div(HL_DIVU, 32'd77, 32'd5, DIV_LAT - 1);
        // flush in IDLE drops the op
        bus.op_valid = 1'b1; bus.op = HL_MTHI; bus.rs_val = 32'hDEAD_0001; bus.flush = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        chk_busy("flush_idle_busy", 1'b0);
        chk_hilo("flush_idle_hilo");
        do_div(HL_DIVU, 32'd77, 32'd5, -1);
    endtask

    task automatic test_back_to_back();
        do_div(HL_DIVU, 32'hFFFF_0000, 32'd255, -1);
        do_div(HL_DIV, 32'h8765_4321, 32'hFFFF_FF00, -1);
        do_mt(HL_MTLO, 32'h0BAD_F00D);
        do_div(HL_DIV, 32'd50, 32'hFFFF_FFFB, -1);
    endtask

    task automatic test_ignored_op();
        logic [63:0] res;
        bus.op_valid = 1'b1; bus.op = HL_DIVU; bus.rs_val = 32'd90; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.op = HL_MTHI; bus.rs_val = 32'hCAFE_CAFE; bus.rt_val = 32'd1;
        @(negedge clk);
        bus.op = HL_DIV;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk_ops("ignored_ops", 32'd90, 32'd4, 1'b0);
        repeat (DIV_LAT - 2) @(negedge clk);
        res = ref_div(HL_DIVU, 32'd90, 32'd4);
        exp_lo = res[63:32];
        exp_hi = res[31:0];
        chk_busy("ignored_busy", 1'b0);
        chk_hilo("ignored_result");
    endtask

    task automatic test_async_reset();
        do_mt(HL_MTHI, 32'h1111_2222);
        bus.op_valid = 1'b1; bus.op = HL_DIV; bus.rs_val = 32'd999; bus.rt_val = 32'd10;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        chk_busy("arst_busy", 1'b0);
        chk_hilo("arst_hilo");
        chk_ops("arst_ops", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV_LAT) @(negedge clk);
        chk_busy("arst_after_busy", 1'b0);
        chk_hilo("arst_after_hilo");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (op == HL_DIV || op == HL_DIVU)
                do_div(op, a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DIV_LAT - 1)) : -1);
            else
                do_mt(op, a);
        end
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op = HL_DIV; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero_ovf();
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_ignored_op();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Owns the architectural HI/LO registers and sequences the combinational divider across a fixed multi-cycle window.
- Sits in EX, directly downstream of the divider, and drives its dividend, divisor and sign inputs.
- Captures rs/rt for DIV/DIVU and holds them stable for DIV_LAT cycles. The divider path is constrained as a multicycle path.
- Writes quotient to LO and remainder to HI, executes MTHI/MTLO, and raises busy so the hazard unit stalls HI/LO consumers.

Parameters:
- DIV_LAT, 4: cycles the divider inputs are held before q/r are sampled; legal range 1..15.
- W, 32: datapath width. Fixed at 32 for MIPS; any other value is unsupported.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  EX holds a HI/LO-class instruction this cycle
- op  in  2  operation code (encodings in Decomposition)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- flush  in  1  kill EX instruction and abort any in-flight divide
- div_dividend  out  32  to divider, registered
- div_divisor  out  32  to divider, registered
- div_sign  out  1  to divider, registered; 1 = signed
- div_q  in  32  from divider
- div_r  in  32  from divider
- busy  out  1  divide in flight
- hi  out  32  HI register, read by MFHI
- lo  out  32  LO register, read by MFLO

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, div_dividend=0, div_divisor=0, div_sign=0, state=IDLE, count=0.
- States: IDLE, RUN.
- Accept: an op is accepted on a rising edge when op_valid=1, flush=0 and state=IDLE.
- IDLE + accepted DIV/DIVU:
  - latch div_dividend=rs_val, div_divisor=rt_val, div_sign=(op==DIV).
  - count=DIV_LAT-1; go to RUN; busy=1 from the next cycle.
- IDLE + accepted MTHI: hi<=rs_val next edge. Accepted MTLO: lo<=rs_val next edge. State stays IDLE.
- RUN with count!=0: count decrements each edge; divider inputs held constant.
- RUN with count==0, on that edge:
  - divisor!=0: lo<=div_q, hi<=div_r.
  - divisor==0: lo<=32'hFFFF_FFFF, hi<=div_dividend, regardless of sign. div_q/div_r are ignored.
  - state<=IDLE, busy<=0.
- Timing: busy is high for exactly DIV_LAT cycles. New HI/LO values are visible in the first cycle busy=0.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: take the divider result unmodified (lo=0x8000_0000, hi=0).
- Back-to-back: a new op may be accepted in the first cycle after busy falls. No bubble is required.
- op_valid while RUN: the op is ignored. A simulation assertion fires; the hazard unit must stall instead.
- flush=1 in IDLE: the op is ignored.
- flush=1 in RUN: abort to IDLE next edge, busy<=0, hi/lo unchanged, divider inputs retain their values.
- flush on the same edge as the RUN count==0 completion: flush wins; no write.
- rst_n asserted mid-RUN: immediate return to reset values; no partial write.
- hi/lo outputs come straight from their registers; no bypass of a pending write.

Decomposition:
- Shared package hilo_pkg holds:
  - op encodings HL_DIV=2'd0, HL_DIVU=2'd1, HL_MTHI=2'd2, HL_MTLO=2'd3;
  - state encodings ST_IDLE, ST_RUN;
  - DIV0_LO=32'hFFFF_FFFF.
- The existing divider is instantiated one level up, beside this unit, not inside it.
- No further sub-module: the counter and FSM are small enough to stay in one module.

Test Plan:
- Reset, DIV_LAT=4, DIVU rs=100 rt=7: busy high 4 cycles, then lo=14, hi=2. Divider inputs are stable throughout.
- DIV rs=0xFFFF_FFF9 (-7) rt=2: lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). Repeat with DIVU on the same operands: lo=0x7FFF_FFFC, hi=1.
- DIV rs=0x1234_5678 rt=0: lo=0xFFFF_FFFF, hi=0x1234_5678 after 4 busy cycles. Also DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- MTHI rs=0xA5A5_A5A5, then MTLO rs=0x5A5A_5A5A on consecutive cycles: hi/lo show the values one cycle after each op; busy stays 0.
- DIV started, flush asserted in RUN cycle 2 (or on the final cycle): busy drops next edge, hi/lo keep their prior values. A following DIVU completes normally.
- rst_n pulsed low mid-RUN, asynchronously between edges: outputs clear immediately. Also op_valid=1 during RUN: op ignored, assertion fires, result unaffected.
